// File: rtl/cmult_coef_seq.sv
// Coefficient sequencer for the pipelined complex multiplier: pairs each accepted
// sample with the next table coefficient and tags the products with valid/last.
module cmult_coef_seq #(
  parameter int W        = 16,
  parameter int AW       = 6,
  parameter int MULT_LAT = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cfg_we,
  input  logic [AW-1:0] cfg_addr,
  input  logic [W-1:0]  cfg_ci,
  input  logic [W-1:0]  cfg_cq,
  input  logic [AW-1:0] cfg_len,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_i,
  input  logic [W-1:0]  in_q,
  output logic [W-1:0]  m_xi,
  output logic [W-1:0]  m_xq,
  output logic [W-1:0]  m_ci,
  output logic [W-1:0]  m_cq,
  output logic          m_ce,
  input  logic [W-1:0]  m_pi,
  input  logic [W-1:0]  m_pq,
  output logic          out_valid,
  output logic [W-1:0]  out_i,
  output logic [W-1:0]  out_q,
  output logic          out_last,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t          r_state;
  logic [2*W-1:0]  r_tab [2**AW];
  logic [AW-1:0]   r_idx;
  logic [AW-1:0]   r_len;
  logic            r_opv;
  logic            r_opl;
  logic [MULT_LAT:0] r_vpipe;
  logic [MULT_LAT:0] r_lpipe;

  logic            w_accept;
  logic            w_last_acc;
  logic [2*W-1:0]  w_coef;

  assign w_coef     = r_tab[r_idx];
  assign w_accept   = (r_state == S_RUN) && in_valid;
  assign w_last_acc = w_accept && (r_idx == r_len);

  assign in_ready  = (r_state == S_RUN);
  assign busy      = (r_state != S_IDLE);
  assign m_ce      = busy;
  assign out_valid = r_vpipe[MULT_LAT];
  assign out_last  = r_lpipe[MULT_LAT];
  assign done      = out_valid && out_last;
  assign out_i     = m_pi;
  assign out_q     = m_pq;

  // Table has no reset; writes are only honoured while idle.
  always_ff @(posedge clk) begin
    if ((r_state == S_IDLE) && cfg_we)
      r_tab[cfg_addr] <= {cfg_ci, cfg_cq};
  end

  // r_opv/r_opl flag the operand registers; the multiplier's own input stage
  // plus MULT_LAT stages are then tracked by the (1+MULT_LAT)-deep pipes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_len   <= '0;
      r_opv   <= 1'b0;
      r_opl   <= 1'b0;
      r_vpipe <= '0;
      r_lpipe <= '0;
      m_xi    <= '0;
      m_xq    <= '0;
      m_ci    <= '0;
      m_cq    <= '0;
    end else begin
      r_opv   <= w_accept;
      r_opl   <= w_last_acc;
      r_vpipe <= {r_vpipe[MULT_LAT-1:0], r_opv};
      r_lpipe <= {r_lpipe[MULT_LAT-1:0], r_opl};
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_len   <= cfg_len;
            r_idx   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (w_accept) begin
            m_xi <= in_i;
            m_xq <= in_q;
            m_ci <= w_coef[2*W-1:W];
            m_cq <= w_coef[W-1:0];
            if (w_last_acc) begin
              r_idx   <= '0;
              r_state <= S_DRAIN;
            end else begin
              r_idx <= r_idx + AW'(1);
            end
          end
        end
        S_DRAIN: begin
          if (done)
            r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmult_coef_seq.sv
// Bench for cmult_coef_seq: stand-in multiplier, stream-level scoreboard model,
// table-driven directed runs and randomized runs.
module tb_cmult_coef_seq;
  localparam int W  = 16;
  localparam int AW = 6;
  localparam int ML = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          cfg_we = 1'b0;
  logic [AW-1:0] cfg_addr = '0;
  logic [W-1:0]  cfg_ci = '0, cfg_cq = '0;
  logic [AW-1:0] cfg_len = '0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_i = '0, in_q = '0;
  logic [W-1:0]  m_xi, m_xq, m_ci, m_cq, m_pi, m_pq;
  logic          m_ce;
  logic          out_valid, out_last, busy, done;
  logic [W-1:0]  out_i, out_q;

  cmult_coef_seq #(.W(W), .AW(AW), .MULT_LAT(ML)) dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_ci(cfg_ci), .cfg_cq(cfg_cq), .cfg_len(cfg_len), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_i(in_i), .in_q(in_q),
    .m_xi(m_xi), .m_xq(m_xq), .m_ci(m_ci), .m_cq(m_cq), .m_ce(m_ce),
    .m_pi(m_pi), .m_pq(m_pq), .out_valid(out_valid), .out_i(out_i),
    .out_q(out_q), .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] cmul(input logic [15:0] xi, xq, ci, cq);
    int pr, pi;
    pr = int'($signed(xi)) * int'($signed(ci)) - int'($signed(xq)) * int'($signed(cq));
    pi = int'($signed(xi)) * int'($signed(cq)) + int'($signed(xq)) * int'($signed(ci));
    return {pr[15:0], pi[15:0]};
  endfunction

  // Stand-in multiplier: input register plus ML stages, advancing on m_ce.
  logic [31:0] mpipe [ML+1];
  always @(posedge clk) begin
    if (m_ce) begin
      mpipe[0] <= cmul(m_xi, m_xq, m_ci, m_cq);
      for (int i = 1; i <= ML; i++) mpipe[i] <= mpipe[i-1];
    end
  end
  assign m_pi = mpipe[ML][31:16];
  assign m_pq = mpipe[ML][15:0];

  // Reference model: product stream of sample[n] * table[n], each due
  // 1+ML cycles after its accepting edge.
  typedef struct { int cyc; logic [15:0] i, q; logic last; } ev_t;
  ev_t         exp_q[$];
  ev_t         cap_q[$];
  int          acc_q[$];
  logic [31:0] mtab [64];
  bit          m_busy = 0, m_run = 0;
  int          mlen = 0, mn = 0, m_end = 0;

  always @(negedge clk) begin
    ev_t e;
    logic [31:0] p;
    bit ev;
    if (!reset) begin
      chk("rst_in_ready", in_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_m_ce", m_ce, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_done", done, 0);
      chk("rst_m_x", {m_xi, m_xq}, 0);
      chk("rst_m_c", {m_ci, m_cq}, 0);
      m_busy = 0; m_run = 0;
      exp_q.delete();
    end else begin
      chk("busy", busy, m_busy);
      chk("m_ce", m_ce, m_busy);
      chk("in_ready", in_ready, m_run);
      ev = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
      chk("out_valid", out_valid, ev);
      if (ev) begin
        e = exp_q.pop_front();
        if (out_valid) begin
          chk("out_i", out_i, e.i);
          chk("out_q", out_q, e.q);
          chk("out_last", out_last, e.last);
          chk("done", done, e.last);
        end
      end else begin
        chk("done_idle", done, 0);
      end
      if (out_valid) cap_q.push_back('{cyc, out_i, out_q, out_last});
      // inputs now stable are the ones the next edge acts on
      if (!m_busy) begin
        if (cfg_we) mtab[cfg_addr] = {cfg_ci, cfg_cq};
        if (start) begin
          m_busy = 1; m_run = 1; mlen = int'(cfg_len); mn = 0;
        end
      end else if (m_run) begin
        if (in_valid) begin
          acc_q.push_back(cyc + 1);
          p = cmul(in_i, in_q, mtab[mn][31:16], mtab[mn][15:0]);
          exp_q.push_back('{cyc + 2 + ML, p[31:16], p[15:0], mn == mlen});
          if (mn == mlen) begin
            m_run = 0;
            m_end = cyc + 2 + ML;
          end
          mn++;
        end
      end else if (cyc == m_end) begin
        m_busy = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input logic [15:0] ci, input logic [15:0] cq);
    cfg_we = 1; cfg_addr = 6'(a); cfg_ci = ci; cfg_cq = cq;
    tick();
    cfg_we = 0;
  endtask

  task automatic go(input int len);
    cfg_len = 6'(len); start = 1;
    tick();
    start = 0;
  endtask

  task automatic feed(input logic [15:0] xi, input logic [15:0] xq, input int gap);
    int t = 0;
    in_valid = 1; in_i = xi; in_q = xq;
    while (!in_ready && t < 50) begin tick(); t++; end
    if (t == 50) chk("feed_timeout", in_ready, 1);
    tick();
    in_valid = 0;
    repeat (gap) tick();
  endtask

  task automatic wait_idle();
    int t = 0;
    while (busy && t < 300) begin tick(); t++; end
    chk("idle_timeout", busy, 0);
  endtask

  task automatic cmp_cap(input string tag, input int k, input logic [15:0] ei,
                         input logic [15:0] eq, input logic el);
    if (k >= cap_q.size()) begin
      chk($sformatf("%s_missing%0d", tag, k), cap_q.size(), k + 1);
    end else begin
      chk($sformatf("%s_i%0d", tag, k), cap_q[k].i, ei);
      chk($sformatf("%s_q%0d", tag, k), cap_q[k].q, eq);
      chk($sformatf("%s_last%0d", tag, k), cap_q[k].last, el);
    end
  endtask

  typedef struct { logic [15:0] xi, xq, ci, cq, ei, eq; } vec_t;
  vec_t v1 [4];

  task automatic run_v1(input string tag, input int gap);
    cap_q.delete(); acc_q.delete();
    go(3);
    for (int n = 0; n < 4; n++) feed(v1[n].xi, v1[n].xq, gap);
    wait_idle();
    chk({tag, "_count"}, cap_q.size(), 4);
    for (int n = 0; n < 4; n++) cmp_cap(tag, n, v1[n].ei, v1[n].eq, n == 3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    v1[0] = '{16'sd100, 16'sd50, 16'sd1,  16'sd0,  16'sd100,  16'sd50};
    v1[1] = '{16'sd100, 16'sd50, 16'sd0,  16'sd1,  -16'sd50,  16'sd100};
    v1[2] = '{16'sd100, 16'sd50, -16'sd1, 16'sd0,  -16'sd100, -16'sd50};
    v1[3] = '{16'sd100, 16'sd50, 16'sd0,  -16'sd1, 16'sd50,   -16'sd100};

    repeat (3) tick();
    reset = 1;
    tick();

    // back-to-back run, latency and ordering
    for (int n = 0; n < 4; n++) wr(n, v1[n].ci, v1[n].cq);
    run_v1("t1", 0);
    if (cap_q.size() > 0 && acc_q.size() > 0)
      chk("t1_latency", cap_q[0].cyc - acc_q[0], 1 + ML);

    // bubbles every other cycle are preserved
    run_v1("t2", 1);
    for (int n = 1; n < 4 && n < cap_q.size(); n++)
      chk($sformatf("t2_gap%0d", n), cap_q[n].cyc - cap_q[n-1].cyc, 2);

    // single-coefficient run
    wr(0, 16'sd2, 16'sd0);
    cap_q.delete();
    go(0);
    feed(16'sd3, 16'sd4, 0);
    chk("t3_ready_after", in_ready, 0);
    wait_idle();
    chk("t3_count", cap_q.size(), 1);
    cmp_cap("t3", 0, 16'sd6, 16'sd8, 1'b1);
    wr(0, v1[0].ci, v1[0].cq);

    // cfg_we and start during RUN are ignored
    cap_q.delete();
    go(3);
    feed(v1[0].xi, v1[0].xq, 0);
    cfg_we = 1; cfg_addr = 6'd1; cfg_ci = 16'sd7; cfg_cq = 16'sd7;
    start = 1; cfg_len = 6'd0;
    tick();
    cfg_we = 0; start = 0;
    for (int n = 1; n < 4; n++) feed(v1[n].xi, v1[n].xq, 0);
    wait_idle();
    chk("t4_count", cap_q.size(), 4);
    for (int n = 0; n < 4; n++) cmp_cap("t4", n, v1[n].ei, v1[n].eq, n == 3);
    run_v1("t4b", 0);

    // reset mid-run
    cap_q.delete();
    go(3);
    feed(v1[0].xi, v1[0].xq, 0);
    feed(v1[1].xi, v1[1].xq, 0);
    reset = 0;
    #1;
    chk("t5_busy", busy, 0);
    chk("t5_in_ready", in_ready, 0);
    chk("t5_m_ce", m_ce, 0);
    chk("t5_out_valid", out_valid, 0);
    chk("t5_done", done, 0);
    chk("t5_m_x", {m_xi, m_xq}, 0);
    chk("t5_m_c", {m_ci, m_cq}, 0);
    tick(); tick();
    reset = 1;
    repeat (12) tick();
    chk("t5_no_valid", cap_q.size(), 0);
    run_v1("t5", 0);

    // full table, then a short rerun starting again at index 0
    for (int n = 0; n < 64; n++) wr(n, 16'(n), 16'(-n));
    cap_q.delete();
    go(63);
    for (int n = 0; n < 64; n++) feed(16'sd1, 16'sd0, 0);
    wait_idle();
    chk("t6_count", cap_q.size(), 64);
    for (int n = 0; n < 64; n++) cmp_cap("t6", n, 16'(n), 16'(-n), n == 63);
    cap_q.delete();
    go(1);
    feed(16'sd1, 16'sd0, 0);
    feed(16'sd1, 16'sd0, 0);
    wait_idle();
    chk("t6b_count", cap_q.size(), 2);
    cmp_cap("t6b", 0, 16'sd0, 16'sd0, 1'b0);
    cmp_cap("t6b", 1, 16'sd1, -16'sd1, 1'b1);

    // randomized runs, checked by the scoreboard
    for (int r = 0; r < 8; r++) begin
      int len;
      repeat (4) wr($urandom_range(0, 63), 16'($urandom), 16'($urandom));
      len = $urandom_range(0, 24);
      cfg_we = 1; cfg_addr = 6'($urandom_range(0, 63));
      cfg_ci = 16'($urandom); cfg_cq = 16'($urandom);
      cfg_len = 6'(len); start = 1;
      tick();
      cfg_we = 0; start = 0;
      for (int n = 0; n <= len; n++) begin
        if ($urandom_range(0, 3) == 0) begin
          cfg_we = 1; cfg_addr = 6'($urandom_range(0, 63));
          cfg_ci = 16'($urandom); cfg_cq = 16'($urandom);
          start = 1'($urandom_range(0, 1));
          tick();
          cfg_we = 0; start = 0;
        end
        feed(16'($urandom), 16'($urandom), $urandom_range(0, 2));
      end
      wait_idle();
      chk("rnd_drained", exp_q.size(), 0);
    end

    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
